gearbox_33_32_sched: RTL

Packet-granular round-robin scheduler that shares one 33-to-32 gearbox input among NUM_REQ requesters.
- Accepts 33-bit words (bit 32 = control flag) from each requester.
- Holds the grant until end-of-packet.
- Feeds the gearbox through a registered valid/ready stage and obeys the gearbox back-pressure, including its one-cycle stall every 32 input words.
- Optionally inserts idle words so the serial line never starves.

---
 rtl/gearbox_33_32_sched.sv | 111 +++++++++++
 1 files changed

// File: rtl/gearbox_33_32_sched.sv
// Packet-granular round-robin scheduler feeding a 33-to-32 gearbox input through
// a registered valid/ready stage, with optional idle-word fill.
module gearbox_33_32_sched #(
    parameter int          NUM_REQ     = 4,
    parameter int          IDX_W       = 2,
    parameter bit          IDLE_INSERT = 1'b1,
    parameter logic [32:0] IDLE_WORD   = 33'h1_0707_0707
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [NUM_REQ*33-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_eop,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [32:0]          gb_din,
    output logic                 gb_din_valid,
    input  logic                 gb_din_ready,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 active,
    output logic [31:0]          idle_count
);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [32:0]      words [NUM_REQ];
    logic             load;
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             sel_eop;
    logic             accept;
    logic [IDX_W-1:0] ptr_after_sel;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign words[i] = req_data[33*i +: 33];
    end

    assign load   = !gb_din_valid || gb_din_ready;
    assign active = (state == LOCKED);

    // Rotating search starting at rr_ptr; first valid requester wins.
    always_comb begin
        int unsigned pos;
        cand_found = 1'b0;
        cand_idx   = '0;
        pos        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = rr_ptr + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!cand_found && req_valid[pos[IDX_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        if (state == LOCKED) begin
            sel_idx   = grant_idx;
            sel_valid = req_valid[grant_idx];
        end else begin
            sel_idx   = cand_idx;
            sel_valid = cand_found;
        end
        sel_eop       = req_eop[sel_idx];
        accept        = load && sel_valid && !arst;
        ptr_after_sel = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[sel_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = sel_eop ? ARB : LOCKED;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= ARB;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            gb_din       <= '0;
            gb_din_valid <= 1'b0;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            idle_count   <= '0;
        end else if (load) begin
            if (sel_valid) begin
                gb_din       <= words[sel_idx];
                gb_din_valid <= 1'b1;
                grant_idx    <= sel_idx;
                if (sel_eop) rr_ptr <= ptr_after_sel;
            end else if (IDLE_INSERT) begin
                gb_din       <= IDLE_WORD;
                gb_din_valid <= 1'b1;
                if (idle_count != '1) idle_count <= idle_count + 32'd1;
            end else begin
                gb_din_valid <= 1'b0;
            end
        end
    end

endmodule
